// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: issues one fetch at a time, holds the fetched word for
// the next stage, and squashes in-flight fetches when the execute stage redirects.
module ysyx_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic        drop, drop_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] opc_q, opc_d;
    logic [31:0] redir_pc;

    // Word-align the target; masking keeps every input bit in use.
    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            drop   <= 1'b0;
            inst_q <= '0;
            opc_q  <= '0;
        end else begin
            state  <= state_d;
            pc     <= pc_d;
            drop   <= drop_d;
            inst_q <= inst_d;
            opc_q  <= opc_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        drop_d  = drop;
        inst_d  = inst_q;
        opc_d   = opc_q;
        case (state)
            IDLE: begin
                state_d = REQ;
                if (redirect_valid) pc_d = redir_pc;
            end
            REQ: begin
                if (redirect_valid) pc_d = redir_pc;
                if (imem_req_ready) begin
                    state_d = WAIT;
                    drop_d  = redirect_valid;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (imem_rsp_valid) begin
                        state_d = REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop) begin
                        state_d = REQ;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = HOLD;
                        inst_d  = imem_rsp_data;
                        opc_d   = pc;
                    end
                end
            end
            HOLD: begin
                // A redirect wins over the sequential increment even if the transfer fires.
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = REQ;
                end else if (out_ready) begin
                    pc_d    = pc + 32'd4;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign out_valid      = (state == HOLD);
    assign out_inst       = inst_q;
    assign out_pc         = opc_q;

endmodule

// File: tb/tb_ysyx_ifu.sv
// Bench for ysyx_ifu: memory responder plus architectural pc model feeding a
// scoreboard of expected (pc, inst) pairs checked by an independent monitor.
module tb_ysyx_ifu;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    ysyx_ifu #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } xfer_t;

    int unsigned errors = 0;
    int unsigned checks = 0;
    xfer_t       sb[$];

    // Reference model: architectural pc and the single in-flight fetch.
    logic [31:0] m_pc;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    logic [31:0] pend_data;
    bit          pend_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: decide inputs for the coming posedge, update the model, advance.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt,
                        input bit ordy, input int dly, input bit spur);
        bit          rsp;
        logic [31:0] d;
        rsp = 1'b0;
        d   = $urandom;
        if (imem_req_valid) chk("one_outstanding", {31'd0, pend}, 32'd0);
        if (out_valid) chk("valid_exclusive", {31'd0, imem_req_valid}, 32'd0);
        if (pend) begin
            if (redir) pend_drop = 1'b1;
            pend_cnt--;
            if (pend_cnt == 0) begin
                rsp = 1'b1;
                d   = pend_data;
                if (!pend_drop) sb.push_back('{pend_addr, pend_data});
                pend = 1'b0;
            end
        end else if (spur) begin
            rsp = 1'b1;
        end
        if (imem_req_valid && rdy) begin
            chk("req_addr", imem_req_addr, m_pc);
            pend      = 1'b1;
            pend_cnt  = dly;
            pend_addr = m_pc;
            pend_data = (m_pc == RPC) ? 32'h0000_0413 : $urandom;
            pend_drop = redir;
        end
        if (redir) m_pc = tgt & 32'hFFFF_FFFC;
        else if (out_valid && ordy) m_pc = m_pc + 32'd4;
        imem_req_ready = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        out_ready      = ordy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        sb.delete();
        pend = 1'b0;
        m_pc = RPC;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops on each new presentation, then checks it stays stable while held.
    initial begin
        bit    prev;
        xfer_t cur;
        prev = 1'b0;
        cur  = '{32'd0, 32'd0};
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!prev) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
                            cur = '{out_pc, out_inst};
                        end else begin
                            cur = sb.pop_front();
                        end
                    end
                    chk("out_pc", out_pc, cur.pc);
                    chk("out_inst", out_inst, cur.inst);
                end
                prev = out_valid;
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        m_pc           = RPC;
        pend           = 1'b0;
        @(negedge clk);
        do_reset();

        // IDLE cycle, then request stalled by memory
        step(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("stall_addr", imem_req_addr, RPC);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd0);
            step(0, 0, 0, 1, 1, 0);
        end

        // Minimum latency fetch
        step(1, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_out_pc", out_pc, RPC);
        chk("lat_out_inst", out_inst, 32'h0000_0413);
        step(0, 0, 0, 1, 1, 0);
        chk("next_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("next_addr", imem_req_addr, RPC + 32'd4);

        // Back-pressure in HOLD
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
            step(0, 0, 0, 0, 1, 0);
        end
        step(0, 0, 0, 1, 1, 0);

        // Redirect during WAIT drops the response
        step(1, 0, 0, 1, 2, 0);
        step(0, 1, 32'h8000_0103, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("drop_out_valid", {31'd0, out_valid}, 32'd0);
        chk("drop_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("drop_addr", imem_req_addr, 32'h8000_0100);

        // Redirect in HOLD with out_ready high
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("hold_redir_pre_valid", {31'd0, out_valid}, 32'd1);
        step(0, 1, 32'h8000_0200, 1, 1, 0);
        chk("hold_redir_out_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_redir_addr", imem_req_addr, 32'h8000_0200);

        // Reset mid-WAIT, stale responses afterwards
        step(1, 0, 0, 1, 3, 0);
        step(0, 0, 0, 1, 1, 0);
        do_reset();
        step(0, 0, 0, 1, 1, 1);
        chk("rst_first_req", {31'd0, imem_req_valid}, 32'd1);
        chk("rst_first_addr", imem_req_addr, RPC);
        step(0, 0, 0, 1, 1, 1);
        chk("stale_ignored_req", {31'd0, imem_req_valid}, 32'd1);
        chk("stale_ignored_valid", {31'd0, out_valid}, 32'd0);
        step(1, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("post_rst_inst", out_inst, 32'h0000_0413);

        // Randomized traffic, including targets near the top of the address space
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
                step($urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0, tgt,
                     $urandom_range(0, 1) == 1, $urandom_range(1, 3), $urandom_range(0, 9) == 0);
            end
        end

        // Drain outstanding work without issuing new fetches
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_ifu.md
YSYX_IFU -- requirements
Module: ysyx_ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts request; request fires when imem_req_valid && imem_req_ready.
REQ-006 imem_req_addr  output  32  fetch address; equals current pc.
REQ-007 imem_rsp_valid  input  1  one-cycle pulse; fetched word present on imem_rsp_data.
REQ-008 imem_rsp_data  input  32  fetched instruction word.
REQ-009 out_valid  output  1  instruction/pc pair valid for the decode/execute stage.
REQ-010 out_ready  input  1  consumer accepts; transfer fires when out_valid && out_ready.
REQ-011 out_inst  output  32  held instruction word.
REQ-012 out_pc  output  32  address of out_inst.
REQ-013 redirect_valid  input  1  one-cycle pulse from the execute stage (taken branch/jump).
REQ-014 redirect_pc  input  32  redirect target (execute-stage jump_addr).

Function
REQ-015 The block SHALL implement a four-state FSM: IDLE, REQ, WAIT, HOLD.
REQ-016 IDLE SHALL unconditionally move to REQ on the next edge; imem_req_valid=0 and out_valid=0 in IDLE.
REQ-017 In REQ, imem_req_valid SHALL be 1; on request fire the FSM SHALL move to WAIT.
REQ-018 In REQ with imem_req_valid && !imem_req_ready, imem_req_addr SHALL be held stable unless a redirect occurs.
REQ-019 In WAIT, imem_rsp_valid SHALL capture imem_rsp_data into out_inst and pc into out_pc, and the FSM SHALL move to HOLD.
REQ-020 out_valid SHALL be 1 exactly in HOLD; out_inst/out_pc SHALL remain stable while in HOLD.
REQ-021 In HOLD, transfer fire SHALL set pc <= pc + 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) and move to REQ.
REQ-022 Minimum latency: request fire at cycle N, response at N+1, out_valid=1 at N+2; minimum 3 cycles between transfers.
REQ-023 imem_rsp_valid outside WAIT SHALL be ignored (no state or output change).
REQ-024 Redirect SHALL load pc <= {redirect_pc[31:2], 2'b00}.
REQ-025 Redirect in IDLE or in REQ without fire: pc updated, FSM goes/stays REQ, new address presented next cycle.
REQ-026 Redirect in REQ coinciding with request fire: FSM SHALL go to WAIT with drop flag set.
REQ-027 Redirect in WAIT: drop flag SHALL be set; if imem_rsp_valid is in the same cycle, that response SHALL be discarded and FSM goes to REQ.
REQ-028 A response arriving in WAIT with drop flag set SHALL be discarded, drop flag cleared, FSM to REQ; out_valid SHALL stay 0.
REQ-029 Redirect in HOLD SHALL move to REQ, out_valid=0 next cycle; if out_ready is high the same cycle the transfer still fires but pc SHALL take the redirect target, not pc + 4.
REQ-030 At most one request SHALL be outstanding at any time.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, drop flag=0, out_inst=0, out_pc=0, out_valid=0, imem_req_valid=0.
REQ-032 Reset asserted mid-operation (REQ/WAIT/HOLD) SHALL abandon the in-flight fetch; a stale response after reset release SHALL be ignored per REQ-023.
REQ-033 First imem_req_valid=1 SHALL appear one cycle after reset release, with imem_req_addr=RESET_PC.

Verification
REQ-034 Reset release, req_ready=1, rsp one cycle after fire with data 32'h0000_0413, out_ready=1 -> out_valid at cycle 3 with out_pc=32'h8000_0000, out_inst=32'h0000_0413; next request addr 32'h8000_0004.
REQ-035 imem_req_ready=0 for 5 cycles -> imem_req_valid stays 1, addr stable at 32'h8000_0000, no out_valid.
REQ-036 out_ready=0 for 4 cycles in HOLD -> out_valid, out_inst, out_pc stable; no new request issued.
REQ-037 Redirect to 32'h8000_0103 during WAIT, rsp next cycle -> response discarded, next request addr 32'h8000_0100, out_valid never asserted for dropped word.
REQ-038 Redirect to 32'h8000_0200 in HOLD with out_ready=1 same cycle -> transfer fires once, next request addr 32'h8000_0200 (not pc+4).
REQ-039 rst_n pulsed low during WAIT, stale rsp_valid after release -> ignored; first request after release at RESET_PC.
